// File: rtl/debounce_pkg_amisha.sv
// Shared state encodings and default sizing for the switch debouncer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debounce_pkg_amisha;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    // Prescaler width: one sample tick every 2^19 clocks (~10.5 ms at 50 MHz)
    localparam int DEFAULT_N            = 19;
    // Consecutive stable sample ticks needed before a level change is accepted
    localparam int DEFAULT_STABLE_TICKS = 3;

    // Width of a counter holding 0..ticks-1; never narrower than one bit
    function automatic int cnt_width(input int ticks);
        return (ticks <= 2) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/debounce_tick_gen_amisha.sv
// Sample-tick prescaler: free-running N-bit counter, m_tick high while it sits at all-ones.
// Latency: first tick 2^N-1 cycles after reset release, then every 2^N cycles.
// Backpressure: none; free-running, no flow control.
module debounce_tick_gen_amisha
    import debounce_pkg_amisha::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic clk_amisha,
    input  logic reset_amisha,
    output logic m_tick_amisha
);

    logic [N-1:0] q;

    // Free-running up-counter, wraps naturally from all-ones to zero
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            q <= '0;
        end else begin
            q <= q + 1'b1;
        end
    end

    assign m_tick_amisha = (q == {N{1'b1}});

endmodule

// File: rtl/debounce_fsm_amisha.sv
// Switch debouncer: clean level plus one-cycle rising-edge tick; DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer.
// Latency: (STABLE_TICKS-1)*2^N+1 .. STABLE_TICKS*2^N cycles from a stable input change (+2 with DEBOUNCE_SYNC_EN).
// Backpressure: none; input sampled every cycle, outputs are unconditional.
module debounce_fsm_amisha
    import debounce_pkg_amisha::*;
#(
    parameter int N            = DEFAULT_N,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic clk_amisha,
    input  logic reset_amisha,
    input  logic sw_amisha,
    output logic db_level_amisha,
    output logic db_tick_amisha
);

    localparam int             CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          m_tick_amisha;
    logic          sw_s;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_ff;

    // Two-flop synchronizer for an asynchronous raw switch input
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], sw_amisha};
        end
    end

    assign sw_s = sync_ff[1];
`else
    // Caller guarantees sw_amisha is already synchronous to clk_amisha
    assign sw_s = sw_amisha;
`endif

    debounce_tick_gen_amisha #(
        .N (N)
    ) u_tick_gen (
        .clk_amisha    (clk_amisha),
        .reset_amisha  (reset_amisha),
        .m_tick_amisha (m_tick_amisha)
    );

    // State and sample-counter registers
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state_reg <= ZERO;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state, sample count and Mealy tick; a reverting input beats a sample tick
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        db_tick_amisha = 1'b0;
        case (state_reg)
            ZERO: begin
                if (sw_s) begin
                    state_next = WAIT1;
                    cnt_next   = '0;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_next = ZERO;
                end else if (m_tick_amisha) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next     = ONE;
                        db_tick_amisha = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_next = WAIT0;
                    cnt_next   = '0;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_next = ONE;
                end else if (m_tick_amisha) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next = ZERO;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ZERO;
                cnt_next   = '0;
            end
        endcase
    end

    // Debounced level is a pure decode of the registered state
    assign db_level_amisha = (state_reg == ONE) || (state_reg == WAIT0);

endmodule
